hazard_flush_ctrl: RTL and testbench

//  Generates the stall/flush controls for the ID/EX pipeline register and the front end (PC, IF/ID).

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/hazard_flush_ctrl_if.sv | 27 ++
 rtl/sat_counter.sv | 17 +
 rtl/hazard_flush_ctrl.sv | 88 ++++++++
 tb/tb_hazard_flush_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared hazard/flush types, state encoding and NOP/bubble constants
package hazard_pkg;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_LU_STALL = 1'b1
    } hz_state_e;

    // Contents written into IF/ID and ID/EX when they are cleared
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] BUBBLE_PC = 32'hffff_ffff;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN    = 4'b1100;
    localparam hz_ctrl_t CTRL_STALL  = 4'b0001;
    localparam hz_ctrl_t CTRL_BRANCH = 4'b1111;
    localparam hz_ctrl_t CTRL_RESET  = 4'b0011;

    function automatic logic load_use(input logic       mem_read,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2,
                                      input logic       uses_rs2);
        return mem_read && (rd != 5'd0) &&
               ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// rtl/hazard_flush_ctrl_if.sv - decode/execute hazard inputs and pipeline control outputs
interface hazard_flush_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             br_taken_ex;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd, br_taken_ex,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd, br_taken_ex,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, stall_cycles, flush_events
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end
endmodule

// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - load-use stall and taken-branch flush control with statistics
module hazard_flush_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_flush_ctrl_if.slave bus
);
    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL - 1);

    hz_state_e  r_state;
    logic [3:0] r_cnt;
    logic       w_hz;
    hz_ctrl_t   w_ctrl;
    logic       w_inc_stall;
    logic       w_inc_flush;

    assign w_hz = load_use(bus.ex_mem_read, bus.ex_rd, bus.id_rs1, bus.id_rs2, bus.id_uses_rs2);

    // A taken branch always wins: the instruction in ID is on the wrong path
    always_comb begin
        w_ctrl      = CTRL_RUN;
        w_inc_stall = 1'b0;
        w_inc_flush = 1'b0;
        if (rst) begin
            w_ctrl = CTRL_RESET;
        end else if (bus.br_taken_ex) begin
            w_ctrl      = CTRL_BRANCH;
            w_inc_flush = 1'b1;
        end else if ((r_state == HZ_LU_STALL) || w_hz) begin
            w_ctrl      = CTRL_STALL;
            w_inc_stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HZ_RUN;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                HZ_RUN: begin
                    if (!bus.br_taken_ex && w_hz && (LOAD_STALL > 1)) begin
                        r_state <= HZ_LU_STALL;
                        r_cnt   <= STALL_RELOAD;
                    end
                end
                HZ_LU_STALL: begin
                    if (bus.br_taken_ex) begin
                        r_state <= HZ_RUN;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state <= HZ_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= HZ_RUN;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.pc_write    = w_ctrl.pc_write;
    assign bus.if_id_write = w_ctrl.if_id_write;
    assign bus.if_id_flush = w_ctrl.if_id_flush;
    assign bus.id_ex_flush = w_ctrl.id_ex_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_inc_stall),
        .q   (bus.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_inc_flush),
        .q   (bus.flush_events)
    );
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb/tb_hazard_flush_ctrl.sv - scoreboard bench over four differently parameterised instances
module tb_hazard_flush_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    logic rst3 = 1'b1;

    hazard_flush_ctrl_if #(.CNT_W(32)) u_if0();
    hazard_flush_ctrl_if #(.CNT_W(32)) u_if1();
    hazard_flush_ctrl_if #(.CNT_W(32)) u_if2();
    hazard_flush_ctrl_if #(.CNT_W(4))  u_if3();

    hazard_flush_ctrl #(.LOAD_STALL(1), .CNT_W(32)) u_dut0 (.clk(clk), .rst(rst0), .bus(u_if0.slave));
    hazard_flush_ctrl #(.LOAD_STALL(3), .CNT_W(32)) u_dut1 (.clk(clk), .rst(rst1), .bus(u_if1.slave));
    hazard_flush_ctrl #(.LOAD_STALL(4), .CNT_W(32)) u_dut2 (.clk(clk), .rst(rst2), .bus(u_if2.slave));
    hazard_flush_ctrl #(.LOAD_STALL(1), .CNT_W(4))  u_dut3 (.clk(clk), .rst(rst3), .bus(u_if3.slave));

    typedef struct {
        int         sel;
        logic [3:0] ctl;
        int         stall;
        int         flush;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [3:0] RUN = 4'b1100;
    localparam logic [3:0] STL = 4'b0001;
    localparam logic [3:0] BRN = 4'b1111;
    localparam logic [3:0] RST = 4'b0011;

    task automatic step(input int sel, input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u2, input logic mr, input logic [4:0] rd, input logic br,
                        input logic [3:0] ectl, input int est, input int efl, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        case (sel)
            0: begin rst0 = r; u_if0.id_rs1 = rs1; u_if0.id_rs2 = rs2; u_if0.id_uses_rs2 = u2;
                     u_if0.ex_mem_read = mr; u_if0.ex_rd = rd; u_if0.br_taken_ex = br; end
            1: begin rst1 = r; u_if1.id_rs1 = rs1; u_if1.id_rs2 = rs2; u_if1.id_uses_rs2 = u2;
                     u_if1.ex_mem_read = mr; u_if1.ex_rd = rd; u_if1.br_taken_ex = br; end
            2: begin rst2 = r; u_if2.id_rs1 = rs1; u_if2.id_rs2 = rs2; u_if2.id_uses_rs2 = u2;
                     u_if2.ex_mem_read = mr; u_if2.ex_rd = rd; u_if2.br_taken_ex = br; end
            default: begin rst3 = r; u_if3.id_rs1 = rs1; u_if3.id_rs2 = rs2; u_if3.id_uses_rs2 = u2;
                     u_if3.ex_mem_read = mr; u_if3.ex_rd = rd; u_if3.br_taken_ex = br; end
        endcase
        e.sel = sel; e.ctl = ectl; e.stall = est; e.flush = efl; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int sel, input logic [3:0] ectl, input int est, input int efl, input string nm);
        step(sel, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, ectl, est, efl, nm);
    endtask

    // Monitor: controls are combinational, so every stimulus cycle yields one observation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [3:0] act_ctl;
            int         act_st;
            int         act_fl;
            e = exp_q.pop_front();
            case (e.sel)
                0: begin act_ctl = {u_if0.pc_write, u_if0.if_id_write, u_if0.if_id_flush, u_if0.id_ex_flush};
                         act_st = int'(u_if0.stall_cycles); act_fl = int'(u_if0.flush_events); end
                1: begin act_ctl = {u_if1.pc_write, u_if1.if_id_write, u_if1.if_id_flush, u_if1.id_ex_flush};
                         act_st = int'(u_if1.stall_cycles); act_fl = int'(u_if1.flush_events); end
                2: begin act_ctl = {u_if2.pc_write, u_if2.if_id_write, u_if2.if_id_flush, u_if2.id_ex_flush};
                         act_st = int'(u_if2.stall_cycles); act_fl = int'(u_if2.flush_events); end
                default: begin act_ctl = {u_if3.pc_write, u_if3.if_id_write, u_if3.if_id_flush, u_if3.id_ex_flush};
                         act_st = {28'd0, u_if3.stall_cycles}; act_fl = {28'd0, u_if3.flush_events}; end
            endcase
            checks++;
            if (act_ctl !== e.ctl) begin
                failures++;
                $display("FAIL %s ctl: got %b want %b", e.name, act_ctl, e.ctl);
            end
            checks++;
            if (act_st != e.stall || act_fl != e.flush) begin
                failures++;
                $display("FAIL %s cnt: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         e.name, act_st, act_fl, e.stall, e.flush);
            end
        end
    end

    initial begin
        u_if0.id_rs1 = 0; u_if0.id_rs2 = 0; u_if0.id_uses_rs2 = 0; u_if0.ex_mem_read = 0; u_if0.ex_rd = 0; u_if0.br_taken_ex = 0;
        u_if1.id_rs1 = 0; u_if1.id_rs2 = 0; u_if1.id_uses_rs2 = 0; u_if1.ex_mem_read = 0; u_if1.ex_rd = 0; u_if1.br_taken_ex = 0;
        u_if2.id_rs1 = 0; u_if2.id_rs2 = 0; u_if2.id_uses_rs2 = 0; u_if2.ex_mem_read = 0; u_if2.ex_rd = 0; u_if2.br_taken_ex = 0;
        u_if3.id_rs1 = 0; u_if3.id_rs2 = 0; u_if3.id_uses_rs2 = 0; u_if3.ex_mem_read = 0; u_if3.ex_rd = 0; u_if3.br_taken_ex = 0;
        @(posedge clk);

        // Reset: flushes asserted, write enables low, counters zero
        step(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, RST, 0, 0, "rst0_a");
        step(0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, RST, 0, 0, "rst0_b");
        step(3, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, RST, 0, 0, "rst3");
        idle(0, RUN, 0, 0, "post_rst");

        // LOAD_STALL=1: single bubble on rs1 match
        step(0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, STL, 0, 0, "ls1_stall");
        idle(0, RUN, 1, 0, "ls1_resume");
        idle(0, RUN, 1, 0, "ls1_hold");

        // LOAD_STALL=3: rs2 hazard held through the stall, then rs2 unused
        idle(1, RUN, 0, 0, "ls3_pre");
        step(1, 1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, STL, 0, 0, "ls3_s1");
        step(1, 1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, STL, 1, 0, "ls3_s2");
        step(1, 1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, STL, 2, 0, "ls3_s3");
        idle(1, RUN, 3, 0, "ls3_run");
        step(1, 1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, RUN, 3, 0, "ls3_no_rs2");
        idle(1, RUN, 3, 0, "ls3_after");

        // x0 never hazards; branch beats a simultaneous hazard
        step(0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, RUN, 1, 0, "x0_nohz");
        step(0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, BRN, 1, 0, "br_over_hz");
        idle(0, RUN, 1, 1, "br_after");

        // LOAD_STALL=4: reset in 2nd stall cycle
        step(2, 1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, STL, 0, 0, "ls4_s1");
        step(2, 1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, RST, 1, 0, "ls4_rst");
        idle(2, RUN, 0, 0, "ls4_post_rst");
        // Branch inside LU_STALL returns to RUN
        step(2, 1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, STL, 0, 0, "ls4_b_s1");
        idle(2, STL, 1, 0, "ls4_b_s2");
        step(2, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, BRN, 2, 0, "ls4_branch");
        idle(2, RUN, 2, 1, "ls4_b_run");
        // Full four-cycle stall after the branch proves cnt was cleared
        step(2, 1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, STL, 2, 1, "ls4_f1");
        idle(2, STL, 3, 1, "ls4_f2");
        idle(2, STL, 4, 1, "ls4_f3");
        idle(2, STL, 5, 1, "ls4_f4");
        idle(2, RUN, 6, 1, "ls4_f_run");

        // CNT_W=4: flush counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            step(3, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, BRN, 0, (i > 15) ? 15 : i, "sat_br");
        end
        idle(3, RUN, 0, 15, "sat_hold");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
